// File: rtl/bram_stream_loader_pkg.sv
// -----------------------------------------------------------------------------
// bram_stream_loader_pkg
// Shared definitions for the stream loader and the 11-entry weight/bias bank:
//   - DEF_RAM_WIDTH / DEF_RAM_DEPTH : default bank geometry
//   - state_t                       : loader FSM encoding
//   - clogb2()                      : address-width helper, same formula as the bank
// No ports (package).
// -----------------------------------------------------------------------------
package bram_stream_loader_pkg;

  localparam int DEF_RAM_WIDTH = 16;
  localparam int DEF_RAM_DEPTH = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  // Number of bits needed to represent 'depth' (clogb2(10) = 4).
  function automatic int clogb2(input int depth);
    int r;
    int d;
    r = 0;
    d = depth;
    while (d > 0) begin
      r++;
      d = d >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_stream_loader.sv
// -----------------------------------------------------------------------------
// bram_stream_loader
// Fills the parallel-output weight/bias bank from a valid/ready word stream.
// Words are written at sequential addresses 0..RAM_DEPTH-1; once the set is
// complete the loader raises done and refuses data until the consumer acks.
//
// Ports:
//   clka      in   clock
//   rst_na    in   synchronous active-low reset
//   start     in   one-cycle request to load a new set (honoured in IDLE only)
//   s_data    in   stream data word
//   s_valid   in   stream word valid
//   s_ready   out  loader accepts a word this cycle
//   s_last    in   stream end-of-set marker (only checked, never used for control)
//   addra     out  bank write address (registered)
//   dina      out  bank write data (registered)
//   wea       out  bank write enable, one-cycle pulse per accepted word
//   busy      out  high while loading
//   done      out  high while the bank holds a complete set
//   ack       in   consumer has taken the set; release FULL
//   word_cnt  out  words accepted in the current set (holds RAM_DEPTH in FULL)
//   last_err  out  only with BRAM_LOADER_LAST_CHECK_EN defined: sticky flag for
//                  an s_last marker that disagrees with the word count
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; stream stalled
//   LOAD  | accepting words, one bank write per handshake
//   FULL  | set complete, done high, waiting for ack
// -----------------------------------------------------------------------------
module bram_stream_loader
  import bram_stream_loader_pkg::*;
#(
  parameter  int RAM_WIDTH = DEF_RAM_WIDTH,
  parameter  int RAM_DEPTH = DEF_RAM_DEPTH,
  localparam int ADDR_W    = clogb2(RAM_DEPTH - 1)
) (
  input  logic                 clka,
  input  logic                 rst_na,
  input  logic                 start,
  input  logic [RAM_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  output logic [ADDR_W-1:0]    addra,
  output logic [RAM_WIDTH-1:0] dina,
  output logic                 wea,
  output logic                 busy,
  output logic                 done,
  input  logic                 ack,
`ifdef BRAM_LOADER_LAST_CHECK_EN
  output logic                 last_err,
`endif
  output logic [ADDR_W-1:0]    word_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(RAM_DEPTH - 1);

  state_t state;
  logic   hs;
  logic   at_last;

  assign hs      = s_valid & s_ready;
  assign at_last = (word_cnt == LAST_IDX);

  always_ff @(posedge clka) begin
    if (!rst_na) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      wea      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      addra    <= '0;
      dina     <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wea <= 1'b0;
          if (start) begin
            state    <= LOAD;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            word_cnt <= '0;
          end
        end

        LOAD: begin
          wea <= hs;
          if (hs) begin
            addra    <= word_cnt;
            dina     <= s_data;
            word_cnt <= word_cnt + ADDR_W'(1);
            // s_ready drops together with entering FULL, capping the set at
            // RAM_DEPTH writes no matter what the stream does.
            if (at_last) begin
              state   <= FULL;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end

        FULL: begin
          wea <= 1'b0;
          // ack takes priority; a coincident start is deliberately dropped.
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          wea     <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRAM_LOADER_LAST_CHECK_EN
  // Flags s_last on the wrong word or missing on the final word. Pure status:
  // the FSM ignores it.
  always_ff @(posedge clka) begin
    if (!rst_na) begin
      last_err <= 1'b0;
    end else if (state == IDLE && start) begin
      last_err <= 1'b0;
    end else if (state == LOAD && hs && (s_last != at_last)) begin
      last_err <= 1'b1;
    end
  end
`else
  // The set length comes from the count alone; s_last is only consumed by the
  // optional marker check.
  logic unused_s_last;
  assign unused_s_last = s_last;
`endif

endmodule

// File: tb/tb_bram_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_loader
// Directed bench for bram_stream_loader. Every accepted word pushes its expected
// bank write onto a queue; a monitor pops and compares on each wea pulse.
// Define BRAM_LOADER_LAST_CHECK_EN to also cover last_err.
// -----------------------------------------------------------------------------
module tb_bram_stream_loader;

  localparam int W = 16;
  localparam int D = 11;
  localparam int A = 4;

  typedef struct packed {
    logic [A-1:0] a;
    logic [W-1:0] d;
  } wr_t;

  logic         clka = 1'b0;
  logic         rst_na = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         s_last = 1'b0;
  logic [A-1:0] addra;
  logic [W-1:0] dina;
  logic         wea;
  logic         busy;
  logic         done;
  logic         ack = 1'b0;
  logic [A-1:0] word_cnt;
`ifdef BRAM_LOADER_LAST_CHECK_EN
  logic         last_err;
`endif

  int  n_assert = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];
  int  exp_cnt  = 0;
  logic [W-1:0] bank [D];

  bram_stream_loader dut (
    .clka    (clka),
    .rst_na  (rst_na),
    .start   (start),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .addra   (addra),
    .dina    (dina),
    .wea     (wea),
    .busy    (busy),
    .done    (done),
    .ack     (ack),
`ifdef BRAM_LOADER_LAST_CHECK_EN
    .last_err(last_err),
`endif
    .word_cnt(word_cnt)
  );

  always #5 clka = ~clka;

  // Bank model: what the downstream register bank would capture.
  always @(posedge clka) begin
    if (wea && addra < A'(D)) bank[addra] <= dina;
  end

  // Scoreboard monitor.
  always @(negedge clka) begin
    if (wea) begin
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addra=%0d dina=0x%04h, required no write", addra, dina);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (addra !== e.a || dina !== e.d) begin
          n_fail++;
          $display("FAIL bank_write: got addra=%0d dina=0x%04h, required addra=%0d dina=0x%04h",
                   addra, dina, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic send_word(input logic [W-1:0] d, input logic l);
    bit hs;
    int guard;
    hs = 1'b0;
    guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!hs && guard < 20) begin
      hs = s_ready;
      tick();
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!hs) begin
      n_assert++;
      n_fail++;
      $display("FAIL handshake_timeout: got s_ready=0 for 20 cycles, required acceptance of 0x%04h", d);
    end else begin
      exp_q.push_back('{a: A'(exp_cnt), d: d});
      exp_cnt++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_wea"},     32'(wea), 0);
    chk({tag, "_busy"},    32'(busy), 0);
    chk({tag, "_done"},    32'(done), 0);
    chk({tag, "_addra"},   32'(addra), 0);
    chk({tag, "_dina"},    32'(dina), 0);
    chk({tag, "_word_cnt"},32'(word_cnt), 0);
  endtask

  task automatic load_full_set(input logic [W-1:0] base);
    for (int i = 0; i < D; i++) send_word(base + W'(i), (i == D - 1));
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    chk_all_zero("reset");
`ifdef BRAM_LOADER_LAST_CHECK_EN
    chk("reset_last_err", 32'(last_err), 0);
`endif
    rst_na = 1'b1;
    tick();
    chk("idle_s_ready", 32'(s_ready), 0);

    // Back-to-back load 0x0001..0x000B
    pulse_start();
    chk("load_s_ready", 32'(s_ready), 1);
    chk("load_busy",    32'(busy), 1);
    chk("load_cnt0",    32'(word_cnt), 0);
    load_full_set(16'h0001);
    chk("full_done",    32'(done), 1);
    chk("full_wea_last",32'(wea), 1);
    chk("full_s_ready", 32'(s_ready), 0);
    chk("full_busy",    32'(busy), 0);
    chk("full_cnt",     32'(word_cnt), D);
    tick();
    for (int i = D - 1; i >= 0; i--) chk("bank_read", 32'(bank[i]), 32'(i + 1));

    // FULL ignores stream data
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    repeat (5) begin
      tick();
      chk("full_hold_s_ready", 32'(s_ready), 0);
      chk("full_hold_done",    32'(done), 1);
    end
    s_valid = 1'b0;
    pulse_ack();
    chk("ack_done", 32'(done), 0);
    chk("ack_s_ready", 32'(s_ready), 0);

    // Gapped load
    pulse_start();
    chk("restart_cnt", 32'(word_cnt), 0);
    for (int i = 0; i < D; i++) begin
      send_word(16'h0100 + W'(i), (i == D - 1));
      if (i < D - 1) begin
        chk("gap_done_low", 32'(done), 0);
        tick();
      end
    end
    chk("gap_full_done", 32'(done), 1);
    chk("gap_full_s_ready", 32'(s_ready), 0);
    pulse_ack();

    // Reset mid-load after 6 words
    pulse_start();
    for (int i = 0; i < 6; i++) send_word(16'h0200 + W'(i), 1'b0);
    chk("mid_cnt6", 32'(word_cnt), 6);
    rst_na = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst_na = 1'b1;
    tick();
    chk("midrst_idle_s_ready", 32'(s_ready), 0);
    pulse_start();
    load_full_set(16'h0300);
    chk("after_rst_done", 32'(done), 1);

    // start and ack together: ack wins, start dropped
    start = 1'b1;
    ack   = 1'b1;
    tick();
    start = 1'b0;
    ack   = 1'b0;
    chk("sa_done", 32'(done), 0);
    chk("sa_s_ready", 32'(s_ready), 0);
    tick();
    chk("sa_dropped_s_ready", 32'(s_ready), 0);
    chk("sa_dropped_busy", 32'(busy), 0);

`ifdef BRAM_LOADER_LAST_CHECK_EN
    // Early s_last on word 7
    pulse_start();
    for (int i = 0; i < D; i++) begin
      send_word(16'h0400 + W'(i), (i == 6));
      if (i == 5) chk("lerr_before", 32'(last_err), 0);
      if (i == 6) chk("lerr_set", 32'(last_err), 1);
    end
    chk("lerr_sticky", 32'(last_err), 1);
    chk("lerr_done", 32'(done), 1);
    pulse_ack();
    pulse_start();
    chk("lerr_cleared", 32'(last_err), 0);
    // Missing s_last on the final word
    for (int i = 0; i < D; i++) send_word(16'h0500 + W'(i), 1'b0);
    chk("lerr_missing_last", 32'(last_err), 1);
    pulse_ack();
`endif

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_stream_loader.md
Name: bram_stream_loader

Overview:
- Upstream fill stage for the 11-entry parallel-output weight/bias register bank.
- Accepts one RAM_WIDTH word per valid/ready handshake from the DMA/unpacker stream.
- Drives the bank's addra/dina/wea write port at sequential addresses 0..RAM_DEPTH-1.
- Signals done when the whole set is loaded, then holds off new data until the consumer acknowledges.

Parameters:
- RAM_WIDTH, 16: data word width; matches the bank.
- RAM_DEPTH, 11: entries per set; matches the bank.
- ADDR_W (localparam), clogb2(RAM_DEPTH-1): write address width; same formula as the bank, 4 for the defaults.

Ports:
- clka  in  1  clock.
- rst_na  in  1  synchronous active-low reset, sampled on posedge clka.
- start  in  1  single-cycle request to begin loading a new set.
- s_data  in  RAM_WIDTH  stream data word.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader accepts a word this cycle.
- s_last  in  1  stream marks the final word of a set.
- addra  out  ADDR_W  bank write address (registered).
- dina  out  RAM_WIDTH  bank write data (registered).
- wea  out  1  bank write enable (registered, one-cycle pulse per word).
- busy  out  1  high while in LOAD.
- done  out  1  high (level) while in FULL.
- ack  in  1  consumer has taken the bank contents; release FULL.
- word_cnt  out  ADDR_W  number of words accepted in the current set.

Behaviour:
- Reset (rst_na=0 at posedge): state=IDLE; s_ready, wea, busy, done = 0; addra, dina, word_cnt = 0. Error flag also 0 when compiled in.
- Reset mid-LOAD: abort to IDLE; a partially written bank is left as-is (the bank clears itself on the same rst_na).
- FSM states: IDLE, LOAD, FULL. All outputs are registered.
- IDLE:
  - s_ready=0.
  - start=1 -> LOAD next cycle, word_cnt=0.
  - ack is ignored.
- LOAD:
  - s_ready=1, busy=1.
  - Handshake = s_valid & s_ready. On handshake, next cycle drives wea=1, addra=word_cnt, dina=s_data; word_cnt increments.
  - Latency from handshake to the bank write edge: 1 cycle.
  - No handshake -> wea=0 next cycle. Gaps in s_valid are allowed and do not change state.
  - Handshake while word_cnt==RAM_DEPTH-1 -> FULL next cycle. s_ready drops to 0 in that same next cycle, so there are never more than RAM_DEPTH writes per set.
  - s_last does not shorten or extend the set; the count alone terminates it.
  - start is ignored.
- FULL:
  - done=1, s_ready=0, busy=0. wea=1 only in the first FULL cycle (the final word's write).
  - ack=1 -> IDLE next cycle, done=0.
  - start is ignored. If start and ack are both high in the same cycle, ack wins (-> IDLE) and start is dropped; the requester must re-issue it.
- addra never exceeds RAM_DEPTH-1, and the address never wraps inside a set.
- word_cnt saturates at RAM_DEPTH in FULL and clears to 0 on entry to LOAD.

Optional Feature:
- Macro: BRAM_LOADER_LAST_CHECK_EN.
- Defined: adds output port last_err (1 bit, reset 0).
  - last_err is set when a handshake has s_last=1 with word_cnt != RAM_DEPTH-1.
  - last_err is also set when the final handshake (word_cnt==RAM_DEPTH-1) has s_last=0.
  - It is sticky until rst_na or the next start, and is a flag only: FSM behaviour is unchanged.
- Undefined: no last_err port; s_last is unused (lint waiver).

Decomposition:
- Shared package:
  - clogb2 function, shared with the bank.
  - FSM state encoding (IDLE=2'd0, LOAD=2'd1, FULL=2'd2).
  - Default RAM_WIDTH/RAM_DEPTH constants.
- No sub-module; counter and FSM are inline.

Test Plan:
- Reset then start, 11 back-to-back words 0x0001..0x000B with s_last on word 11 -> wea pulses on 11 consecutive cycles at addra 0..10 with matching dina; done=1 the cycle after the last write; bank reads 0x000B..0x0001 (high to low).
- Same load with s_valid toggled every other cycle -> 11 writes with gaps, addresses strictly sequential, done only after word 11, s_ready=0 in FULL.
- In FULL, drive s_valid=1 for 5 cycles, then ack -> no wea; IDLE next cycle; start again -> word_cnt restarts at 0 and addra restarts at 0.
- rst_na=0 after 6 words accepted -> all outputs 0 next cycle, state IDLE; a subsequent start plus 11 words completes normally.
- In FULL, assert start and ack in the same cycle -> IDLE, done=0, s_ready stays 0 (start dropped).
- With BRAM_LOADER_LAST_CHECK_EN: s_last on word 7 -> last_err=1 the cycle after that handshake, load still completes 11 words; next start clears last_err.
